// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcode values,
// sequencer states, the strobe bundle produced by the decoder and small
// opcode classification helpers used by both decode and next-state logic.
package control_unit_pkg;

    localparam int unsigned OPC_W    = 5;
    localparam int unsigned ALU_OP_W = 5;

    localparam logic [OPC_W-1:0] OPC_LD   = 5'd0;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_ST   = 5'd2;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'd3;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'd4;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'd5;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'd6;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'd12;
    localparam logic [OPC_W-1:0] OPC_ANDI = 5'd13;
    localparam logic [OPC_W-1:0] OPC_ORI  = 5'd14;
    localparam logic [OPC_W-1:0] OPC_BR   = 5'd19;
    localparam logic [OPC_W-1:0] OPC_JR   = 5'd20;
    localparam logic [OPC_W-1:0] OPC_IN   = 5'd22;
    localparam logic [OPC_W-1:0] OPC_OUT  = 5'd23;
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'd26;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'd27;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_e;

    typedef struct packed {
        // bus drivers
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic ba_out;
        logic in_port_out;
        logic c_out;
        logic r_out;
        logic hi_out;
        logic lo_out;
        // latch enables
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic zhigh_in;
        logic r_in;
        logic hi_in;
        logic lo_in;
        logic con_in;
        logic out_port_in;
        logic in_port_in;
        // register select / PC / memory
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic write;
    } strobes_t;

    function automatic logic is_alu_r(input logic [OPC_W-1:0] op);
        return (op == OPC_ADD) || (op == OPC_SUB) || (op == OPC_AND) || (op == OPC_OR);
    endfunction

    function automatic logic is_alu_i(input logic [OPC_W-1:0] op);
        return (op == OPC_ADDI) || (op == OPC_ANDI) || (op == OPC_ORI);
    endfunction

    // ld, ldi and st all form an effective address as Rb(or 0) + C.
    function automatic logic uses_base_addr(input logic [OPC_W-1:0] op);
        return (op == OPC_LD) || (op == OPC_LDI) || (op == OPC_ST);
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// ctrl_decode: pure combinational decode of (state, opcode, con_ff) into the
// datapath strobe bundle, the ALU operation and the run flag.
//   state   in   current sequencer state
//   opcode  in   IR[31:27]; only meaningful from T3 on
//   con_ff  in   branch condition, used in the final br step
//   strobes out  every control strobe of the datapath
//   alu_op  out  operation for the ALU while zlow_in is high, else 0
//   run     out  1 in every state except RST and HALT
module ctrl_decode
    import control_unit_pkg::*;
(
    input  state_e                state,
    input  logic [OPC_W-1:0]      opcode,
    input  logic                  con_ff,
    output strobes_t              strobes,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  run
);

    always_comb begin
        strobes = '0;
        alu_op  = '0;
        run     = (state != ST_RST) && (state != ST_HALT);

        case (state)
            ST_T0: begin
                strobes.pc_out = 1'b1;
                strobes.mar_in = 1'b1;
                strobes.inc_pc = 1'b1;
                strobes.pc_in  = 1'b1;
            end
            ST_T1: begin
                strobes.read   = 1'b1;
                strobes.mdr_in = 1'b1;
            end
            ST_T2: begin
                strobes.mdr_out = 1'b1;
                strobes.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (uses_base_addr(opcode)) begin
                    strobes.grb    = 1'b1;
                    strobes.ba_out = 1'b1;
                    strobes.y_in   = 1'b1;
                end else if (is_alu_r(opcode) || is_alu_i(opcode)) begin
                    strobes.grb   = 1'b1;
                    strobes.r_out = 1'b1;
                    strobes.y_in  = 1'b1;
                end else begin
                    case (opcode)
                        OPC_BR: begin
                            strobes.gra    = 1'b1;
                            strobes.r_out  = 1'b1;
                            strobes.con_in = 1'b1;
                        end
                        OPC_JR: begin
                            strobes.gra   = 1'b1;
                            strobes.r_out = 1'b1;
                            strobes.pc_in = 1'b1;
                        end
                        OPC_IN: begin
                            strobes.in_port_out = 1'b1;
                            strobes.gra         = 1'b1;
                            strobes.r_in        = 1'b1;
                        end
                        OPC_OUT: begin
                            strobes.gra         = 1'b1;
                            strobes.r_out       = 1'b1;
                            strobes.out_port_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_T4: begin
                if (uses_base_addr(opcode)) begin
                    strobes.c_out   = 1'b1;
                    strobes.zlow_in = 1'b1;
                    alu_op          = OPC_ADD;
                end else if (is_alu_r(opcode)) begin
                    strobes.grc     = 1'b1;
                    strobes.r_out   = 1'b1;
                    strobes.zlow_in = 1'b1;
                    alu_op          = opcode;
                end else if (is_alu_i(opcode)) begin
                    strobes.c_out   = 1'b1;
                    strobes.zlow_in = 1'b1;
                    alu_op          = opcode;
                end else if (opcode == OPC_BR) begin
                    strobes.pc_out = 1'b1;
                    strobes.y_in   = 1'b1;
                end
            end
            ST_T5: begin
                if ((opcode == OPC_LDI) || is_alu_r(opcode) || is_alu_i(opcode)) begin
                    strobes.zlow_out = 1'b1;
                    strobes.gra      = 1'b1;
                    strobes.r_in     = 1'b1;
                end else if ((opcode == OPC_LD) || (opcode == OPC_ST)) begin
                    strobes.zlow_out = 1'b1;
                    strobes.mar_in   = 1'b1;
                end else if (opcode == OPC_BR) begin
                    strobes.c_out   = 1'b1;
                    strobes.zlow_in = 1'b1;
                    alu_op          = OPC_ADD;
                end
            end
            ST_T6: begin
                case (opcode)
                    OPC_LD: begin
                        strobes.read   = 1'b1;
                        strobes.mdr_in = 1'b1;
                    end
                    OPC_ST: begin
                        strobes.gra    = 1'b1;
                        strobes.r_out  = 1'b1;
                        strobes.mdr_in = 1'b1;
                    end
                    OPC_BR: begin
                        if (con_ff) begin
                            strobes.zlow_out = 1'b1;
                            strobes.pc_in    = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (opcode)
                    OPC_LD: begin
                        strobes.mdr_out = 1'b1;
                        strobes.gra     = 1'b1;
                        strobes.r_in    = 1'b1;
                    end
                    OPC_ST: begin
                        strobes.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired T-state sequencer for the Mini-SRC datapath.
// Fetches through PC/MAR/MDR, decodes ir[31:27] and walks the per-opcode
// T-state sequence, waiting on mem_ready for every memory access.
//   clock, clear  posedge clock, synchronous active-high reset
//   ir            instruction register contents (opcode = ir[31:27])
//   con_ff        branch condition flip-flop
//   mem_ready     memory completed the current Read/Write this cycle
//   alu_op        ALU operation while Zlowin is high
//   run           1 while sequencing, 0 in RST and HALT
//   remaining     datapath bus drivers, latch enables and strobes
module control_unit
    import control_unit_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    input  logic [31:0]           ir,
    input  logic                  con_ff,
    input  logic                  mem_ready,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  run,
    output logic                  PCout,
    output logic                  Zlowout,
    output logic                  Zhighout,
    output logic                  MDRout,
    output logic                  BAout,
    output logic                  InPortout,
    output logic                  Cout,
    output logic                  Rout,
    output logic                  HIout,
    output logic                  LOout,
    output logic                  PCin,
    output logic                  MARin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Zlowin,
    output logic                  Zhighin,
    output logic                  Rin,
    output logic                  HIin,
    output logic                  LOin,
    output logic                  CONin,
    output logic                  OutPortin,
    output logic                  InPortin,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  Grc,
    output logic                  IncPC,
    output logic                  Read,
    output logic                  Write
);

    state_e           state_q;
    state_e           state_d;
    logic [OPC_W-1:0] opcode;
    strobes_t         strobes;

    assign opcode = ir[31:27];

    // Register fields are decoded by the datapath, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[26:0];

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  if (mem_ready) state_d = ST_T2;
            ST_T2:  state_d = ST_T3;
            ST_T3: begin
                if (uses_base_addr(opcode) || is_alu_r(opcode) || is_alu_i(opcode)
                    || (opcode == OPC_BR)) begin
                    state_d = ST_T4;
                end else if ((opcode == OPC_JR) || (opcode == OPC_IN)
                             || (opcode == OPC_OUT) || (opcode == OPC_NOP)) begin
                    state_d = ST_T0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_T4: begin
                if (uses_base_addr(opcode) || is_alu_r(opcode) || is_alu_i(opcode)
                    || (opcode == OPC_BR)) begin
                    state_d = ST_T5;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_T5: begin
                if ((opcode == OPC_LDI) || is_alu_r(opcode) || is_alu_i(opcode)) begin
                    state_d = ST_T0;
                end else if ((opcode == OPC_LD) || (opcode == OPC_ST) || (opcode == OPC_BR)) begin
                    state_d = ST_T6;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_T6: begin
                case (opcode)
                    OPC_LD:  if (mem_ready) state_d = ST_T7;
                    OPC_ST:  state_d = ST_T7;
                    OPC_BR:  state_d = ST_T0;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_T7: begin
                case (opcode)
                    OPC_LD:  state_d = ST_T0;
                    OPC_ST:  if (mem_ready) state_d = ST_T0;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .con_ff  (con_ff),
        .strobes (strobes),
        .alu_op  (alu_op),
        .run     (run)
    );

    assign PCout     = strobes.pc_out;
    assign Zlowout   = strobes.zlow_out;
    assign Zhighout  = strobes.zhigh_out;
    assign MDRout    = strobes.mdr_out;
    assign BAout     = strobes.ba_out;
    assign InPortout = strobes.in_port_out;
    assign Cout      = strobes.c_out;
    assign Rout      = strobes.r_out;
    assign HIout     = strobes.hi_out;
    assign LOout     = strobes.lo_out;
    assign PCin      = strobes.pc_in;
    assign MARin     = strobes.mar_in;
    assign MDRin     = strobes.mdr_in;
    assign IRin      = strobes.ir_in;
    assign Yin       = strobes.y_in;
    assign Zlowin    = strobes.zlow_in;
    assign Zhighin   = strobes.zhigh_in;
    assign Rin       = strobes.r_in;
    assign HIin      = strobes.hi_in;
    assign LOin      = strobes.lo_in;
    assign CONin     = strobes.con_in;
    assign OutPortin = strobes.out_port_in;
    assign InPortin  = strobes.in_port_in;
    assign Gra       = strobes.gra;
    assign Grb       = strobes.grb;
    assign Grc       = strobes.grc;
    assign IncPC     = strobes.inc_pc;
    assign Read      = strobes.read;
    assign Write     = strobes.write;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_ready;
    logic [4:0]  alu_op;
    logic        run;
    logic PCout, Zlowout, Zhighout, MDRout, BAout, InPortout, Cout, Rout, HIout, LOout;
    logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin, HIin, LOin, CONin, OutPortin, InPortin;
    logic Gra, Grb, Grc, IncPC, Read, Write;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .alu_op(alu_op), .run(run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .BAout(BAout),
        .InPortout(InPortout), .Cout(Cout), .Rout(Rout), .HIout(HIout), .LOout(LOout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
        .Zhighin(Zhighin), .Rin(Rin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
        .OutPortin(OutPortin), .InPortin(InPortin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write)
    );

    always #5 clock = ~clock;

    // Strobe masks; bus drivers occupy bits 28..19.
    localparam logic [28:0] PCOUT     = 29'd1 << 28;
    localparam logic [28:0] ZLOWOUT   = 29'd1 << 27;
    localparam logic [28:0] ZHIGHOUT  = 29'd1 << 26;
    localparam logic [28:0] MDROUT    = 29'd1 << 25;
    localparam logic [28:0] BAOUT     = 29'd1 << 24;
    localparam logic [28:0] INPORTOUT = 29'd1 << 23;
    localparam logic [28:0] COUT      = 29'd1 << 22;
    localparam logic [28:0] ROUT      = 29'd1 << 21;
    localparam logic [28:0] HIOUT     = 29'd1 << 20;
    localparam logic [28:0] LOOUT     = 29'd1 << 19;
    localparam logic [28:0] PCIN      = 29'd1 << 18;
    localparam logic [28:0] MARIN     = 29'd1 << 17;
    localparam logic [28:0] MDRIN     = 29'd1 << 16;
    localparam logic [28:0] IRIN      = 29'd1 << 15;
    localparam logic [28:0] YIN       = 29'd1 << 14;
    localparam logic [28:0] ZLOWIN    = 29'd1 << 13;
    localparam logic [28:0] ZHIGHIN   = 29'd1 << 12;
    localparam logic [28:0] RIN       = 29'd1 << 11;
    localparam logic [28:0] HIIN      = 29'd1 << 10;
    localparam logic [28:0] LOIN      = 29'd1 << 9;
    localparam logic [28:0] CONIN     = 29'd1 << 8;
    localparam logic [28:0] OUTPORTIN = 29'd1 << 7;
    localparam logic [28:0] INPORTIN  = 29'd1 << 6;
    localparam logic [28:0] GRA       = 29'd1 << 5;
    localparam logic [28:0] GRB       = 29'd1 << 4;
    localparam logic [28:0] GRC       = 29'd1 << 3;
    localparam logic [28:0] INCPC     = 29'd1 << 2;
    localparam logic [28:0] READ      = 29'd1 << 1;
    localparam logic [28:0] WRITE     = 29'd1 << 0;

    localparam logic [31:0] I_LDI   = 32'h09800054; // ldi R3,0x54(R0)
    localparam logic [31:0] I_LD    = 32'h00800075; // ld R1,0x75
    localparam logic [31:0] I_ST    = 32'h11000020; // st 0x20,R2
    localparam logic [31:0] I_ADD   = 32'h1A920000; // add R5,R2,R4
    localparam logic [31:0] I_SUB   = 32'h22920000;
    localparam logic [31:0] I_ORI   = 32'h72900007;
    localparam logic [31:0] I_BR    = 32'h99000010;
    localparam logic [31:0] I_JR    = 32'hA1000000;
    localparam logic [31:0] I_IN    = 32'hB1800000;
    localparam logic [31:0] I_OUT   = 32'hB9800000;
    localparam logic [31:0] I_NOP   = 32'hD0000000;
    localparam logic [31:0] I_HALT  = 32'hD8000000;
    localparam logic [31:0] I_UNDEF = 32'hF8000000;

    logic [34:0] exp_q[$];
    string       name_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [34:0] ev(input logic r, input logic [4:0] a, input logic [28:0] s);
        return {r, a, s};
    endfunction

    // Monitor: one expectation per checked cycle, compared mid-cycle.
    always @(negedge clock) begin
        logic [34:0] e;
        logic [34:0] obs;
        string       nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            obs = {run, alu_op,
                   PCout, Zlowout, Zhighout, MDRout, BAout, InPortout, Cout, Rout, HIout, LOout,
                   PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin, HIin, LOin, CONin,
                   OutPortin, InPortin, Gra, Grb, Grc, IncPC, Read, Write};
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL %s: got run=%0d alu_op=%0d strobes=%h, expected run=%0d alu_op=%0d strobes=%h",
                         nm, obs[34], obs[33:29], obs[28:0], e[34], e[33:29], e[28:0]);
            end
            vectors++;
            if ($countones(obs[28:19]) > 1) begin
                miscompares++;
                $display("FAIL %s_bus: got %0d bus drivers, expected at most 1", nm, $countones(obs[28:19]));
            end
        end
    end

    task automatic step(input logic [31:0] ir_v, input logic mr, input logic cf,
                        input logic clr, input logic [34:0] e, input string nm);
        @(posedge clock);
        #1;
        ir        = ir_v;
        mem_ready = mr;
        con_ff    = cf;
        clear     = clr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic fetch(input logic [31:0] ir_v);
        step(ir_v, 1'b1, 1'b0, 1'b0, ev(1, 0, PCOUT | MARIN | INCPC | PCIN), "t0");
        step(ir_v, 1'b1, 1'b0, 1'b0, ev(1, 0, READ | MDRIN), "t1");
        step(ir_v, 1'b1, 1'b0, 1'b0, ev(1, 0, MDROUT | IRIN), "t2");
    endtask

    task automatic alu_seq(input logic [31:0] ir_v, input logic [4:0] op, input logic imm, input string nm);
        fetch(ir_v);
        step(ir_v, 1, 0, 0, ev(1, 0, GRB | ROUT | YIN), {nm, "_t3"});
        if (imm) step(ir_v, 1, 0, 0, ev(1, op, COUT | ZLOWIN), {nm, "_t4"});
        else     step(ir_v, 1, 0, 0, ev(1, op, GRC | ROUT | ZLOWIN), {nm, "_t4"});
        step(ir_v, 1, 0, 0, ev(1, 0, ZLOWOUT | GRA | RIN), {nm, "_t5"});
    endtask

    task automatic br_seq(input logic cf);
        fetch(I_BR);
        step(I_BR, 1, cf, 0, ev(1, 0, GRA | ROUT | CONIN), "br_t3");
        step(I_BR, 1, cf, 0, ev(1, 0, PCOUT | YIN), "br_t4");
        step(I_BR, 1, cf, 0, ev(1, 3, COUT | ZLOWIN), "br_t5");
        if (cf) step(I_BR, 1, 1, 0, ev(1, 0, ZLOWOUT | PCIN), "br_t6_taken");
        else    step(I_BR, 1, 0, 0, ev(1, 0, '0), "br_t6_not_taken");
    endtask

    initial begin
        clear = 1'b1; ir = '0; mem_ready = 1'b0; con_ff = 1'b0;

        step('0, 0, 0, 0, ev(0, 0, '0), "reset");

        // ldi
        fetch(I_LDI);
        step(I_LDI, 1, 0, 0, ev(1, 0, GRB | BAOUT | YIN), "ldi_t3");
        step(I_LDI, 1, 0, 0, ev(1, 3, COUT | ZLOWIN), "ldi_t4");
        step(I_LDI, 1, 0, 0, ev(1, 0, ZLOWOUT | GRA | RIN), "ldi_t5");

        // ld with two wait cycles in T6
        fetch(I_LD);
        step(I_LD, 1, 0, 0, ev(1, 0, GRB | BAOUT | YIN), "ld_t3");
        step(I_LD, 1, 0, 0, ev(1, 3, COUT | ZLOWIN), "ld_t4");
        step(I_LD, 1, 0, 0, ev(1, 0, ZLOWOUT | MARIN), "ld_t5");
        step(I_LD, 0, 0, 0, ev(1, 0, READ | MDRIN), "ld_t6_wait1");
        step(I_LD, 0, 0, 0, ev(1, 0, READ | MDRIN), "ld_t6_wait2");
        step(I_LD, 1, 0, 0, ev(1, 0, READ | MDRIN), "ld_t6_ready");
        step(I_LD, 1, 0, 0, ev(1, 0, MDROUT | GRA | RIN), "ld_t7");

        // st with one wait cycle in T7
        fetch(I_ST);
        step(I_ST, 1, 0, 0, ev(1, 0, GRB | BAOUT | YIN), "st_t3");
        step(I_ST, 1, 0, 0, ev(1, 3, COUT | ZLOWIN), "st_t4");
        step(I_ST, 1, 0, 0, ev(1, 0, ZLOWOUT | MARIN), "st_t5");
        step(I_ST, 1, 0, 0, ev(1, 0, GRA | ROUT | MDRIN), "st_t6");
        step(I_ST, 0, 0, 0, ev(1, 0, WRITE), "st_t7_wait");
        step(I_ST, 1, 0, 0, ev(1, 0, WRITE), "st_t7_ready");

        alu_seq(I_ADD, 5'd3, 1'b0, "add");
        alu_seq(I_SUB, 5'd4, 1'b0, "sub");
        alu_seq(I_ORI, 5'd14, 1'b1, "ori");

        br_seq(1'b1);
        br_seq(1'b0);

        fetch(I_JR);
        step(I_JR, 1, 0, 0, ev(1, 0, GRA | ROUT | PCIN), "jr_t3");
        fetch(I_IN);
        step(I_IN, 1, 0, 0, ev(1, 0, INPORTOUT | GRA | RIN), "in_t3");
        fetch(I_OUT);
        step(I_OUT, 1, 0, 0, ev(1, 0, GRA | ROUT | OUTPORTIN), "out_t3");

        // fetch stalled in T1, then nop
        step(I_NOP, 1, 0, 0, ev(1, 0, PCOUT | MARIN | INCPC | PCIN), "wait_t0");
        step(I_NOP, 0, 0, 0, ev(1, 0, READ | MDRIN), "wait_t1a");
        step(I_NOP, 0, 0, 0, ev(1, 0, READ | MDRIN), "wait_t1b");
        step(I_NOP, 1, 0, 0, ev(1, 0, READ | MDRIN), "wait_t1c");
        step(I_NOP, 1, 0, 0, ev(1, 0, MDROUT | IRIN), "wait_t2");
        step(I_NOP, 1, 0, 0, ev(1, 0, '0), "nop_t3");

        // clear while waiting in T1
        step(I_UNDEF, 1, 0, 0, ev(1, 0, PCOUT | MARIN | INCPC | PCIN), "clr_t0");
        step(I_UNDEF, 0, 0, 1, ev(1, 0, READ | MDRIN), "clr_t1");
        step(I_UNDEF, 1, 0, 0, ev(0, 0, '0), "clr_rst");

        // undefined opcode 31 -> HALT
        fetch(I_UNDEF);
        step(I_UNDEF, 1, 0, 0, ev(1, 0, '0), "undef_t3");
        for (int i = 0; i < 3; i++) step(I_UNDEF, 1, 1, 0, ev(0, 0, '0), "undef_halt");
        step(I_UNDEF, 1, 0, 1, ev(0, 0, '0), "undef_halt_clr");
        step(I_HALT, 1, 0, 0, ev(0, 0, '0), "undef_rst");

        // halt opcode, 20 cycles parked, clear back to fetch
        fetch(I_HALT);
        step(I_HALT, 1, 0, 0, ev(1, 0, '0), "halt_t3");
        for (int i = 0; i < 20; i++) step(I_HALT, 1'(i % 2), 1'(i % 3 == 0), 0, ev(0, 0, '0), "halt_park");
        step(I_HALT, 1, 0, 1, ev(0, 0, '0), "halt_clr");
        step(I_HALT, 1, 0, 0, ev(0, 0, '0), "halt_rst");
        step(I_HALT, 1, 0, 0, ev(1, 0, PCOUT | MARIN | INCPC | PCIN), "halt_t0");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
